// File: rtl/div_sequencer_pkg.sv
// Shared types and constants for the RV32M divide sequencer.
package m_ext_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

  localparam logic [31:0] DIV_BY_ZERO_Q = '1;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  // DIV and REM interpret their operands as two's complement
  function automatic logic is_signed_op(input div_op_e op);
    return (op == DIV) || (op == REM);
  endfunction

  // REM and REMU return the remainder rather than the quotient
  function automatic logic is_rem_op(input div_op_e op);
    return (op == REM) || (op == REMU);
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// EX-stage <-> divide sequencer handshake and result bus.
interface div_sequencer_if
  import m_ext_pkg::*;
#(
  parameter int XLEN = 32
);

  logic            div_valid;
  div_op_e         div_opcode;
  logic [XLEN-1:0] operand1;
  logic [XLEN-1:0] operand2;
  logic            flush;
  logic            div_ready;
  logic            div_stall;
  logic            result_valid;
  logic [XLEN-1:0] result_divide;

  // EX stage side: issues ops and flushes, consumes status and results
  modport master (
    output div_valid, div_opcode, operand1, operand2, flush,
    input  div_ready, div_stall, result_valid, result_divide
  );

  // divider side
  modport slave (
    input  div_valid, div_opcode, operand1, operand2, flush,
    output div_ready, div_stall, result_valid, result_divide
  );

endinterface

// File: rtl/div_sequencer_step.sv
// One radix-2 restoring division iteration (combinational).
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dvd_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  // shift in the next dividend bit and subtract when it fits; when it fits the
  // true difference is below 2^XLEN, so only the low XLEN bits are needed
  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted[XLEN-1:0] - divisor;
    q_bit   = (shifted >= {1'b0, divisor});
    rem_out = q_bit ? diff : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divides operand magnitudes one bit per cycle, then fixes signs; divide by
// zero and signed overflow can optionally skip the iteration entirely.
module div_sequencer
  import m_ext_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit FAST_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  div_sequencer_if.slave bus
);

  localparam int              CW       = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_BIT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state;
  div_op_e         op_q;
  logic [XLEN-1:0] dvd_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] result_q;
  logic [CW-1:0]   count_q;
  logic            q_neg_q;
  logic            r_neg_q;
  logic            valid_q;

  logic            accept;
  logic            op_signed;
  logic            op1_neg;
  logic            op2_neg;
  logic            dvs_zero;
  logic            overflow;
  logic            fast;
  logic [XLEN-1:0] op1_mag;
  logic [XLEN-1:0] op2_mag;
  logic [XLEN-1:0] fast_result;
  logic [XLEN-1:0] quo_fixed;
  logic [XLEN-1:0] rem_fixed;
  logic [XLEN-1:0] rem_next;
  logic            q_bit;

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[XLEN-1]),
    .divisor (dvs_q),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // decode the incoming op: magnitudes, special cases and final sign fix-up
  always_comb begin
    accept    = bus.div_valid && (state == IDLE) && !bus.flush;
    op_signed = is_signed_op(bus.div_opcode);
    op1_neg   = op_signed && bus.operand1[XLEN-1];
    op2_neg   = op_signed && bus.operand2[XLEN-1];
    op1_mag   = op1_neg ? -bus.operand1 : bus.operand1;
    op2_mag   = op2_neg ? -bus.operand2 : bus.operand2;
    dvs_zero  = (bus.operand2 == '0);
    overflow  = op_signed && (bus.operand1 == MIN_NEG) && (bus.operand2 == '1);
    fast      = FAST_EN && (dvs_zero || overflow);
    if (dvs_zero) begin
      fast_result = is_rem_op(bus.div_opcode) ? bus.operand1 : '1;
    end else begin
      fast_result = is_rem_op(bus.div_opcode) ? '0 : MIN_NEG;
    end
    quo_fixed = q_neg_q ? -quo_q : quo_q;
    rem_fixed = r_neg_q ? -rem_q : rem_q;
  end

  // sequencer FSM and datapath registers; a zero divisor keeps the all-ones
  // quotient unsigned so the iterative path matches the fast-path result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      op_q     <= DIV;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      count_q  <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= bus.div_opcode;
            dvd_q   <= op1_mag;
            dvs_q   <= op2_mag;
            rem_q   <= '0;
            quo_q   <= '0;
            count_q <= LAST_BIT;
            q_neg_q <= (op1_neg ^ op2_neg) && !dvs_zero;
            r_neg_q <= op1_neg;
            if (fast) begin
              result_q <= fast_result;
              valid_q  <= 1'b1;
              state    <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            rem_q   <= rem_next;
            quo_q   <= {quo_q[XLEN-2:0], q_bit};
            dvd_q   <= {dvd_q[XLEN-2:0], 1'b0};
            count_q <= count_q - 1'b1;
            if (count_q == '0) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            result_q <= is_rem_op(op_q) ? rem_fixed : quo_fixed;
            valid_q  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // status outputs; a flush during DONE hides the pending result pulse
  always_comb begin
    bus.div_ready     = (state == IDLE);
    bus.div_stall     = (state != IDLE) || accept;
    bus.result_valid  = valid_q && !bus.flush;
    bus.result_divide = result_q;
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and randomised checks of div_sequencer with and without the fast path.
module tb_div_sequencer;
  import m_ext_pkg::*;

  logic        clk;
  logic        rst;
  int          checks;
  int          failures;
  logic [31:0] last_exp_f;
  logic        use_f;
  div_op_e     rop;
  logic [31:0] ra;
  logic [31:0] rb;
  logic        fastcond;
  int          seen;

  div_sequencer_if #(.XLEN(32)) bus_f ();
  div_sequencer_if #(.XLEN(32)) bus_s ();

  div_sequencer #(.XLEN(32), .FAST_EN(1'b1)) dut_fast (
    .clk (clk),
    .rst (rst),
    .bus (bus_f)
  );

  div_sequencer #(.XLEN(32), .FAST_EN(1'b0)) dut_slow (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one comparison: count it and report a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // RISC-V M-extension reference divide
  function automatic logic [31:0] ref_div(input div_op_e op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic ovf;
    ovf = (a == INT_MIN) && (b == 32'hFFFF_FFFF);
    case (op)
      DIV:     return (b == 0) ? DIV_BY_ZERO_Q : ovf ? INT_MIN : 32'($signed(a) / $signed(b));
      DIVU:    return (b == 0) ? DIV_BY_ZERO_Q : a / b;
      REM:     return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic obs_valid(input logic f);
    return f ? bus_f.result_valid : bus_s.result_valid;
  endfunction

  function automatic logic obs_stall(input logic f);
    return f ? bus_f.div_stall : bus_s.div_stall;
  endfunction

  function automatic logic [31:0] obs_result(input logic f);
    return f ? bus_f.result_divide : bus_s.result_divide;
  endfunction

  task automatic drive(input logic f, input logic v, input div_op_e op,
                       input logic [31:0] a, input logic [31:0] b);
    if (f) begin
      bus_f.div_valid  = v;
      bus_f.div_opcode = op;
      bus_f.operand1   = a;
      bus_f.operand2   = b;
    end else begin
      bus_s.div_valid  = v;
      bus_s.div_opcode = op;
      bus_s.operand1   = a;
      bus_s.operand2   = b;
    end
  endtask

  // issue one op, wait (bounded) for its result, check latency/value/stall/pulse
  task automatic applyStimulus(input string tag, input logic f, input div_op_e op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_res, input int exp_lat);
    int   lat;
    int   stall_miss;
    logic got;
    lat        = 0;
    stall_miss = 0;
    got        = 1'b0;
    @(negedge clk);
    drive(f, 1'b1, op, a, b);
    #1;
    if (!obs_stall(f)) stall_miss++;
    @(negedge clk);
    drive(f, 1'b0, op, a, b);
    lat = 1;
    while (!got && lat <= 60) begin
      #1;
      if (!obs_stall(f)) stall_miss++;
      if (obs_valid(f)) begin
        got = 1'b1;
      end else begin
        @(negedge clk);
        lat++;
      end
    end
    checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_res"}, obs_result(f), exp_res);
    checkOutput({tag, "_stall"}, 32'(stall_miss), 32'd0);
    @(negedge clk);
    #1;
    checkOutput({tag, "_pulse"}, {31'd0, obs_valid(f)}, 32'd0);
    checkOutput({tag, "_hold"}, obs_result(f), exp_res);
    if (f) last_exp_f = exp_res;
  endtask

  // test sequence
  initial begin
    checks     = 0;
    failures   = 0;
    last_exp_f = '0;
    rst        = 1'b1;
    bus_f.flush = 1'b0;
    bus_s.flush = 1'b0;
    drive(1'b1, 1'b0, DIV, '0, '0);
    drive(1'b0, 1'b0, DIV, '0, '0);
    repeat (2) @(negedge clk);
    checkOutput("rst_ready_f", {31'd0, bus_f.div_ready}, 32'd1);
    checkOutput("rst_stall_f", {31'd0, bus_f.div_stall}, 32'd0);
    checkOutput("rst_valid_f", {31'd0, bus_f.result_valid}, 32'd0);
    checkOutput("rst_result_f", bus_f.result_divide, 32'd0);
    checkOutput("rst_ready_s", {31'd0, bus_s.div_ready}, 32'd1);
    checkOutput("rst_result_s", bus_s.result_divide, 32'd0);
    rst = 1'b0;

    // normal-path arithmetic
    applyStimulus("divu_100_7", 1'b1, DIVU, 32'd100, 32'd7, 32'd14, 34);
    applyStimulus("remu_100_7", 1'b1, REMU, 32'd100, 32'd7, 32'd2, 34);
    applyStimulus("div_m7_2", 1'b1, DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    applyStimulus("rem_m7_2", 1'b1, REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    applyStimulus("div_min_2", 1'b1, DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 34);
    applyStimulus("div_min_2_s", 1'b0, DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 34);

    // fast path and the same cases through the iteration
    applyStimulus("div_5_0_f", 1'b1, DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    applyStimulus("remu_5_0_f", 1'b1, REMU, 32'd5, 32'd0, 32'd5, 1);
    applyStimulus("div_ovf_f", 1'b1, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    applyStimulus("rem_ovf_f", 1'b1, REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    applyStimulus("div_5_0_s", 1'b0, DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 34);
    applyStimulus("remu_5_0_s", 1'b0, REMU, 32'd5, 32'd0, 32'd5, 34);
    applyStimulus("div_ovf_s", 1'b0, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
    applyStimulus("rem_ovf_s", 1'b0, REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34);
    applyStimulus("div_m5_0_s", 1'b0, DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 34);
    applyStimulus("rem_m5_0_s", 1'b0, REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 34);

    // flush in the tenth CALC cycle
    @(negedge clk);
    drive(1'b1, 1'b1, DIVU, 32'd1000, 32'd3);
    @(negedge clk);
    drive(1'b1, 1'b0, DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    bus_f.flush = 1'b1;
    @(negedge clk);
    bus_f.flush = 1'b0;
    #1;
    checkOutput("flush_ready", {31'd0, bus_f.div_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_f.result_valid) seen++;
      @(negedge clk);
    end
    checkOutput("flush_no_result", 32'(seen), 32'd0);
    checkOutput("flush_hold", bus_f.result_divide, last_exp_f);
    applyStimulus("flush_after", 1'b1, DIVU, 32'd9, 32'd3, 32'd3, 34);

    // reset during CALC
    @(negedge clk);
    drive(1'b1, 1'b1, DIVU, 32'd500, 32'd5);
    @(negedge clk);
    drive(1'b1, 1'b0, DIVU, 32'd500, 32'd5);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_ready", {31'd0, bus_f.div_ready}, 32'd1);
    checkOutput("midrst_stall", {31'd0, bus_f.div_stall}, 32'd0);
    checkOutput("midrst_valid", {31'd0, bus_f.result_valid}, 32'd0);
    checkOutput("midrst_result", bus_f.result_divide, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus("rst_after", 1'b1, DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34);

    // random ops on both builds against the reference model
    for (int i = 0; i < 24; i++) begin
      use_f = ((i % 2) == 0);
      rop   = div_op_e'(2'($urandom_range(0, 3)));
      ra    = $urandom();
      rb    = $urandom();
      case ($urandom_range(0, 5))
        0: rb = '0;
        1: rb = '1;
        2: ra = INT_MIN;
        3: begin ra = INT_MIN; rb = '1; end
        4: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      fastcond = (rb == 0) || (is_signed_op(rop) && (ra == INT_MIN) && (rb == '1));
      applyStimulus($sformatf("rnd%0d", i), use_f, rop, ra, rb, ref_div(rop, ra, rb),
                    (use_f && fastcond) ? 1 : 34);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
